// File: rtl/memaccess.sv
// memaccess: Venus memory-access stage; owns the data-memory SRAM port and issues writeback.
// Optional address-fault checking is enabled by defining DMEM_FAULT_EN.
`ifndef WORD
`define WORD 32
`endif
`ifndef W_RD
`define W_RD 5
`endif

module memaccess #(
  parameter int DMEM_AW = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               v_i,
  output logic               stall_o,
  input  logic [1:0]         mop_i,
  input  logic [`WORD-1:0]   addr_i,
  input  logic [`WORD-1:0]   sdata_i,
  input  logic               wb_i,
  input  logic [`W_RD-1:0]   wb_rd_name_i,
  input  logic [`WORD-1:0]   wb_rd_data_i,
  output logic [DMEM_AW-1:0] mem_addr_o,
  output logic               mem_we_o,
  output logic [`WORD-1:0]   mem_d_o,
  input  logic [`WORD-1:0]   mem_q_i,
  output logic               wb_o,
  output logic [`W_RD-1:0]   wb_rd_name_o,
  output logic [`WORD-1:0]   wb_rd_data_o,
  output logic               fault_o,
  output logic [`WORD-1:0]   fault_addr_o
);

  typedef enum logic [1:0] {IDLE, LD_ADDR, LD_WB} state_t;

  state_t             state_q, state_d;
  logic [DMEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic               mem_we_q, mem_we_d;
  logic [`WORD-1:0]   mem_d_q, mem_d_d;
  logic               wb_q, wb_d;
  logic [`W_RD-1:0]   wb_rd_name_q, wb_rd_name_d;
  logic [`WORD-1:0]   wb_rd_data_q, wb_rd_data_d;
  logic               ld_fault_q, ld_fault_d;
  logic               accept, is_load, is_store, addr_bad;

  assign stall_o  = (state_q == LD_ADDR);
  assign accept   = v_i && !stall_o;
  assign is_load  = (mop_i == 2'b01);
  assign is_store = (mop_i == 2'b10);

`ifdef DMEM_FAULT_EN
  logic             fault_q, fault_d;
  logic [`WORD-1:0] fault_addr_q, fault_addr_d;

  assign addr_bad = |addr_i[`WORD-1:DMEM_AW];

  // Only the first faulting address is kept; the flag is sticky until reset.
  always_comb begin
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    if (accept && (is_load || is_store) && addr_bad) begin
      fault_d = 1'b1;
      if (!fault_q) fault_addr_d = addr_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign fault_o      = fault_q;
  assign fault_addr_o = fault_addr_q;
`else
  logic unused_addr_hi;

  assign addr_bad       = 1'b0;
  assign unused_addr_hi = ^addr_i[`WORD-1:DMEM_AW];
  assign fault_o        = 1'b0;
  assign fault_addr_o   = '0;
`endif

  always_comb begin
    state_d      = IDLE;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = 1'b0;
    mem_d_d      = mem_d_q;
    wb_d         = 1'b0;
    wb_rd_name_d = wb_rd_name_q;
    wb_rd_data_d = wb_rd_data_q;
    ld_fault_d   = ld_fault_q;
    if (state_q == LD_ADDR) begin
      state_d = LD_WB;
      wb_d    = 1'b1;
    end else if (accept) begin
      if (is_load) begin
        state_d      = LD_ADDR;
        mem_addr_d   = addr_i[DMEM_AW-1:0];
        wb_rd_name_d = wb_rd_name_i;
        ld_fault_d   = addr_bad;
      end else if (is_store) begin
        mem_addr_d = addr_i[DMEM_AW-1:0];
        mem_d_d    = sdata_i;
        mem_we_d   = !addr_bad;
      end else begin
        wb_d         = wb_i;
        wb_rd_name_d = wb_rd_name_i;
        wb_rd_data_d = wb_rd_data_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_d_q      <= '0;
      wb_q         <= 1'b0;
      wb_rd_name_q <= '0;
      wb_rd_data_q <= '0;
      ld_fault_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_d_q      <= mem_d_d;
      wb_q         <= wb_d;
      wb_rd_name_q <= wb_rd_name_d;
      wb_rd_data_q <= wb_rd_data_d;
      ld_fault_q   <= ld_fault_d;
    end
  end

  assign mem_addr_o   = mem_addr_q;
  assign mem_we_o     = mem_we_q;
  assign mem_d_o      = mem_d_q;
  assign wb_o         = wb_q;
  assign wb_rd_name_o = wb_rd_name_q;
  // Load data comes straight from the SRAM's registered Q during writeback.
  assign wb_rd_data_o = (state_q == LD_WB) ? (ld_fault_q ? '0 : mem_q_i) : wb_rd_data_q;

endmodule

// File: tb/tb_memaccess.sv
// tb_memaccess: scoreboard bench for memaccess with a behavioural registered-read SRAM.
// Expected writebacks and SRAM writes are queued at accept time and checked when they appear.
`timescale 1ns/1ps

module tb_memaccess;

`ifdef DMEM_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  localparam logic [1:0] MOP_PASS  = 2'b00;
  localparam logic [1:0] MOP_LOAD  = 2'b01;
  localparam logic [1:0] MOP_STORE = 2'b10;
  localparam logic [1:0] MOP_RSVD  = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        v_i = 1'b0;
  logic        stall_o;
  logic [1:0]  mop_i = 2'b00;
  logic [31:0] addr_i = '0;
  logic [31:0] sdata_i = '0;
  logic        wb_i = 1'b0;
  logic [4:0]  wb_rd_name_i = '0;
  logic [31:0] wb_rd_data_i = '0;
  logic [15:0] mem_addr_o;
  logic        mem_we_o;
  logic [31:0] mem_d_o;
  logic [31:0] mem_q_i;
  logic        wb_o;
  logic [4:0]  wb_rd_name_o;
  logic [31:0] wb_rd_data_o;
  logic        fault_o;
  logic [31:0] fault_addr_o;

  typedef struct {
    int          cyc;
    logic [4:0]  name;
    logic [31:0] data;
  } wb_exp_t;

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [31:0] data;
  } st_exp_t;

  wb_exp_t     wbQ[$];
  st_exp_t     stQ[$];
  logic [31:0] shadow [int];
  logic [31:0] sram [0:65535];

  int checks   = 0;
  int errors   = 0;
  int cycleCnt = 0;
  int stallCnt = 0;

  memaccess #(.DMEM_AW(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .v_i          (v_i),
    .stall_o      (stall_o),
    .mop_i        (mop_i),
    .addr_i       (addr_i),
    .sdata_i      (sdata_i),
    .wb_i         (wb_i),
    .wb_rd_name_i (wb_rd_name_i),
    .wb_rd_data_i (wb_rd_data_i),
    .mem_addr_o   (mem_addr_o),
    .mem_we_o     (mem_we_o),
    .mem_d_o      (mem_d_o),
    .mem_q_i      (mem_q_i),
    .wb_o         (wb_o),
    .wb_rd_name_o (wb_rd_name_o),
    .wb_rd_data_o (wb_rd_data_o),
    .fault_o      (fault_o),
    .fault_addr_o (fault_addr_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Single-port SRAM with registered read data (read-before-write).
  always @(posedge clk) begin
    if (mem_we_o) sram[mem_addr_o] <= mem_d_o;
    mem_q_i <= sram[mem_addr_o];
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycleCnt);
    end
  endtask

  // Writebacks and SRAM writes are matched against the scoreboard on the falling edge.
  always @(negedge clk) begin
    if (stall_o) stallCnt++;
    if (wb_o) begin
      if (wbQ.size() == 0) begin
        checkOutput("wb_spurious", {63'b0, wb_o}, 64'd0);
      end else begin
        wb_exp_t e;
        e = wbQ.pop_front();
        checkOutput("wb_cycle", cycleCnt, e.cyc);
        checkOutput("wb_name", wb_rd_name_o, e.name);
        checkOutput("wb_data", wb_rd_data_o, e.data);
      end
    end
    if (mem_we_o) begin
      if (stQ.size() == 0) begin
        checkOutput("we_spurious", {63'b0, mem_we_o}, 64'd0);
      end else begin
        st_exp_t s;
        s = stQ.pop_front();
        checkOutput("st_cycle", cycleCnt, s.cyc);
        checkOutput("st_addr", mem_addr_o, s.addr);
        checkOutput("st_data", mem_d_o, s.data);
      end
    end
  end

  task automatic idleCycles(input int n);
    v_i = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one op, waits (bounded) for acceptance, and records expected results.
  // Called at #1 after a rising edge; returns #1 after the accepting edge with v_i still high.
  task automatic applyStimulus(input logic [1:0] mop, input logic [31:0] addr,
                               input logic [31:0] sdata, input logic wb,
                               input logic [4:0] name, input logic [31:0] data,
                               input bit expectOut);
    int waitCycles;
    logic bad;
    logic [15:0] a16;
    waitCycles   = 0;
    v_i          = 1'b1;
    mop_i        = mop;
    addr_i       = addr;
    sdata_i      = sdata;
    wb_i         = wb;
    wb_rd_name_i = name;
    wb_rd_data_i = data;
    @(negedge clk);
    while (stall_o && waitCycles < 20) begin
      waitCycles++;
      @(negedge clk);
    end
    if (stall_o) checkOutput("accept_timeout", {63'b0, stall_o}, 64'd0);
    @(posedge clk);
    #1;
    a16 = addr[15:0];
    bad = FAULT_EN && (addr[31:16] != 16'h0);
    if (expectOut) begin
      if (mop == MOP_LOAD) begin
        wbQ.push_back('{cycleCnt + 1, name,
                        bad ? 32'h0 : (shadow.exists(a16) ? shadow[a16] : 32'h0)});
      end else if (mop == MOP_STORE) begin
        if (!bad) begin
          stQ.push_back('{cycleCnt, a16, sdata});
          shadow[a16] = sdata;
        end
      end else if (wb) begin
        wbQ.push_back('{cycleCnt, name, data});
      end
    end
  endtask

  initial begin
    int stallBase;

    // Reset held two cycles with a valid load presented.
    rst   = 1'b0;
    v_i   = 1'b1;
    mop_i = MOP_LOAD;
    addr_i = 32'h10;
    wb_rd_name_i = 5'd3;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_stall", stall_o, 0);
    checkOutput("rst_wb", wb_o, 0);
    checkOutput("rst_we", mem_we_o, 0);
    checkOutput("rst_maddr", mem_addr_o, 0);
    checkOutput("rst_md", mem_d_o, 0);
    checkOutput("rst_name", wb_rd_name_o, 0);
    checkOutput("rst_data", wb_rd_data_o, 0);
    checkOutput("rst_fault", fault_o, 0);
    checkOutput("rst_faddr", fault_addr_o, 0);
    v_i = 1'b0;
    rst = 1'b1;
    idleCycles(2);

    // Store then back-to-back load of the same address.
    stallBase = stallCnt;
    applyStimulus(MOP_STORE, 32'h10, 32'hDEADBEEF, 1'b1, 5'd9, 32'h1234, 1'b1);
    applyStimulus(MOP_LOAD, 32'h10, 32'h0, 1'b0, 5'd5, 32'h0, 1'b1);
    checkOutput("ld_stall_hi", stall_o, 1);
    idleCycles(4);
    checkOutput("ld_stall_count", stallCnt - stallBase, 1);

    // Pass-through stream r1..r4, then a non-writing and a reserved op.
    stallBase = stallCnt;
    for (int i = 1; i <= 4; i++)
      applyStimulus(MOP_PASS, 32'h0, 32'h0, 1'b1, 5'(i), 32'(i), 1'b1);
    applyStimulus(MOP_PASS, 32'h0, 32'h0, 1'b0, 5'd8, 32'h88, 1'b1);
    applyStimulus(MOP_RSVD, 32'h20, 32'h0, 1'b1, 5'd12, 32'hC0FFEE, 1'b1);
    idleCycles(3);
    checkOutput("stream_stall", stallCnt - stallBase, 0);

    // Load with the following op held through the stall.
    stallBase = stallCnt;
    applyStimulus(MOP_STORE, 32'h44, 32'hA5A5_0044, 1'b0, 5'd0, 32'h0, 1'b1);
    applyStimulus(MOP_LOAD, 32'h44, 32'h0, 1'b1, 5'd6, 32'h0, 1'b1);
    applyStimulus(MOP_PASS, 32'h0, 32'h0, 1'b1, 5'd7, 32'h77, 1'b1);
    applyStimulus(MOP_LOAD, 32'h10, 32'h0, 1'b0, 5'd10, 32'h0, 1'b1);
    idleCycles(4);
    checkOutput("hold_stall_count", stallCnt - stallBase, 2);

    // Reset while in LD_ADDR abandons the load.
    applyStimulus(MOP_LOAD, 32'h10, 32'h0, 1'b1, 5'd11, 32'h0, 1'b0);
    v_i = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midld_stall", stall_o, 0);
    checkOutput("midld_wb", wb_o, 0);
    rst = 1'b1;
    idleCycles(4);
    checkOutput("midld_idle", stall_o, 0);

    // Out-of-range addresses: fault when enabled, truncated otherwise.
    applyStimulus(MOP_STORE, 32'h0001_0000, 32'h1111_2222, 1'b0, 5'd0, 32'h0, 1'b1);
    checkOutput("flt_o", fault_o, FAULT_EN);
    checkOutput("flt_addr", fault_addr_o, FAULT_EN ? 32'h0001_0000 : 32'h0);
    applyStimulus(MOP_STORE, 32'h0002_0000, 32'h3333_4444, 1'b0, 5'd0, 32'h0, 1'b1);
    checkOutput("flt_o2", fault_o, FAULT_EN);
    checkOutput("flt_addr2", fault_addr_o, FAULT_EN ? 32'h0001_0000 : 32'h0);
    applyStimulus(MOP_LOAD, 32'h0001_0000, 32'h0, 1'b0, 5'd13, 32'h0, 1'b1);
    idleCycles(4);

    checkOutput("wbQ_empty", wbQ.size(), 0);
    checkOutput("stQ_empty", stQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
